// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath control sequencer: opcode values and FSM state codes.
package datapath_ctrl_pkg;

  localparam logic [2:0] OPC_LOAD = 3'b000;
  localparam logic [2:0] OPC_MOVE = 3'b001;
  localparam logic [2:0] OPC_ADD  = 3'b010;
  localparam logic [2:0] OPC_XOR  = 3'b011;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET  = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_TRAP   = 3'd4;

endpackage

// File: rtl/datapath_ctrl_seq_step.sv
// Execute step counter for the sequencer: load-0, hold or increment, with a last-step flag.
module ctrl_step_counter #(
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [STEP_W-1:0] last_idx,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (inc) begin
      step_d = step_q + STEP_W'(1);
    end else begin
      step_d = step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;
  assign last = (step_q == last_idx);

endmodule

// File: rtl/datapath_ctrl_seq.sv
// Datapath control sequencer: accepts one instruction per handshake, decodes its opcode and
// steps through a per-opcode number of execute cycles, trapping on illegal opcodes.
module datapath_ctrl_seq
  import datapath_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 25,
  parameter int OPC_LSB    = 22,
  parameter int OPC_W      = 3,
  parameter int STEP_W     = 2,
  parameter int ADD_STEPS  = 3,
  parameter int XOR_STEPS  = 3,
  parameter int LOAD_STEPS = 1,
  parameter int MOVE_STEPS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               exec_stall,
  output logic               exec_en,
  output logic [OPC_W-1:0]   exec_op,
  output logic [STEP_W-1:0]  exec_step,
  output logic               done,
  output logic               illegal,
  output logic               busy
);

  if (ADD_STEPS < 1 || ADD_STEPS > 2**STEP_W || XOR_STEPS < 1 || XOR_STEPS > 2**STEP_W ||
      LOAD_STEPS < 1 || LOAD_STEPS > 2**STEP_W || MOVE_STEPS < 1 || MOVE_STEPS > 2**STEP_W)
  begin : g_bad_steps
    $error("datapath_ctrl_seq: every *_STEPS must lie in 1 .. 2**STEP_W");
  end

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [OPC_W-1:0]   opcode_s;
  logic               opc_legal_s;
  logic [STEP_W-1:0]  last_idx_s;
  logic [STEP_W-1:0]  step_s;
  logic               step_last_s;
  logic               step_clr_s;
  logic               step_inc_s;
  logic               instr_unused_s;

  assign opcode_s       = instr_q[OPC_LSB+OPC_W-1:OPC_LSB];
  assign instr_unused_s = ^instr_q;
  assign opc_legal_s    = (opcode_s == OPC_W'(OPC_LOAD)) || (opcode_s == OPC_W'(OPC_MOVE)) ||
                          (opcode_s == OPC_W'(OPC_ADD))  || (opcode_s == OPC_W'(OPC_XOR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      instr_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_d    = op_q;
    case (state_q)
      ST_RESET:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DECODE: begin
        if (opc_legal_s) begin
          op_d    = opcode_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (exec_stall) begin
          state_d = ST_EXEC;
        end else if (step_last_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_TRAP:   state_d = ST_WAIT;
      default:   state_d = ST_RESET;
    endcase
  end

  // op_q only ever holds a legal opcode, so the default arm is unreachable in practice
  always_comb begin
    last_idx_s = '0;
    case (op_q)
      OPC_W'(OPC_LOAD): last_idx_s = STEP_W'(LOAD_STEPS - 1);
      OPC_W'(OPC_MOVE): last_idx_s = STEP_W'(MOVE_STEPS - 1);
      OPC_W'(OPC_ADD):  last_idx_s = STEP_W'(ADD_STEPS - 1);
      OPC_W'(OPC_XOR):  last_idx_s = STEP_W'(XOR_STEPS - 1);
      default:          last_idx_s = '0;
    endcase
  end

  assign step_clr_s = (state_q == ST_DECODE);
  assign step_inc_s = (state_q == ST_EXEC) && !exec_stall && !step_last_s;

  ctrl_step_counter #(
    .STEP_W (STEP_W)
  ) u_step (
    .clk      (clk),
    .reset    (reset),
    .clr      (step_clr_s),
    .inc      (step_inc_s),
    .last_idx (last_idx_s),
    .step     (step_s),
    .last     (step_last_s)
  );

  always_comb begin
    instr_ready = 1'b0;
    exec_en     = 1'b0;
    exec_op     = '0;
    exec_step   = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_RESET:  busy = 1'b1;
      ST_WAIT: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        exec_en   = 1'b1;
        exec_op   = op_q;
        exec_step = step_s;
        done      = step_last_s && !exec_stall;
      end
      ST_TRAP:   illegal = 1'b1;
      default:   busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_seq.sv
// Scoreboard bench for datapath_ctrl_seq: directed latency scenarios plus randomized traffic.
module tb_datapath_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [24:0] instr = 25'd0;
  logic        dir_stall = 1'b0;
  logic        rand_stall_en = 1'b0;
  logic        rand_stall_bit = 1'b0;
  logic        exec_stall_s;
  logic        instr_ready, exec_en, done, illegal, busy;
  logic [2:0]  exec_op;
  logic [1:0]  exec_step;

  typedef struct packed {
    logic       ill;
    logic [2:0] op;
    logic [1:0] step;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int last_done_cyc = -1, last_ill_cyc = -1, exec_cnt = 0, done_cnt = 0;

  assign exec_stall_s = dir_stall | (rand_stall_en & rand_stall_bit);

  datapath_ctrl_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .exec_stall  (exec_stall_s),
    .exec_en     (exec_en),
    .exec_op     (exec_op),
    .exec_step   (exec_step),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rand_stall_bit = ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at cycle %0d", name, cyc);
  endtask

  // Reference model: LOAD/MOVE take one execute step, ADD/XOR three, anything else traps.
  task automatic model_push(input logic [24:0] w);
    logic [2:0] op;
    int n;
    op = w[24:22];
    case (op)
      3'b000, 3'b001: n = 1;
      3'b010, 3'b011: n = 3;
      default:        n = 0;
    endcase
    if (n == 0) exp_q.push_back('{1'b1, op, 2'd0, 1'b0});
    else for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, op, 2'(i), (i == n - 1)});
  endtask

  // Monitor: inputs change just after posedge, so a negedge sample sees what the next edge will use.
  always begin
    logic rst_prev;
    exp_t e;
    @(posedge clk);
    rst_prev = reset;
    cyc++;
    @(negedge clk);
    if (rst_prev) begin
      exp_q.delete();
      chk("reset_outs", {instr_ready, busy, exec_en, done, illegal, exec_op, exec_step}, 32'h100);
    end else begin
      chk("ready_vs_busy", instr_ready, !busy);
      if (done) begin
        last_done_cyc = cyc;
        done_cnt++;
      end
      if (exec_en) begin
        exec_cnt++;
        chk("illegal_in_exec", illegal, 1'b0);
        if (exp_q.size() == 0) fail_now("unexpected_exec");
        else begin
          e = exp_q[0];
          chk("exec_expected", e.ill, 1'b0);
          chk("exec_op", exec_op, e.op);
          chk("exec_step", exec_step, e.step);
          if (exec_stall_s) chk("done_while_stalled", done, 1'b0);
          else begin
            chk("done", done, e.last);
            void'(exp_q.pop_front());
          end
        end
      end else if (illegal) begin
        last_ill_cyc = cyc;
        chk("illegal_outs", {exec_op, exec_step, done}, 32'd0);
        if (exp_q.size() == 0) fail_now("unexpected_illegal");
        else begin
          e = exp_q.pop_front();
          chk("illegal_expected", e.ill, 1'b1);
        end
      end else begin
        chk("idle_outs", {exec_op, exec_step, done}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [24:0] w, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = w;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        t  = cyc;
        model_push(w);
      end
    end
    if (!ok) fail_now("handshake_timeout");
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int r);
    bit ok;
    ok = 1'b0;
    r  = -1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        r  = cyc;
      end
    end
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic add_case(input string tag);
    int t, r;
    exec_cnt = 0;
    issue({3'b010, 22'h12345}, t);
    drop_valid();
    wait_ready(r);
    chk({tag, "_done_cyc"}, last_done_cyc, t + 4);
    chk({tag, "_ready_cyc"}, r, t + 5);
    chk({tag, "_exec_cycles"}, exec_cnt, 3);
  endtask

  initial begin
    int t, t2, r, dc, g;
    logic [24:0] w;
    logic [2:0] op;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wait_after_reset", {instr_ready, busy, exec_en, done, illegal, exec_op, exec_step}, 32'h200);

    add_case("add");

    // LOAD then MOVE with valid held continuously
    issue({3'b000, 22'h0ABCD}, t);
    issue({3'b001, 22'h3F00F}, t2);
    chk("b2b_second_accept", t2, t + 3);
    chk("b2b_load_done", last_done_cyc, t2 - 1);
    drop_valid();
    wait_ready(r);
    chk("b2b_move_done", last_done_cyc, t2 + 2);
    chk("b2b_move_ready", r, t2 + 3);

    // XOR with two stall cycles on step 1
    exec_cnt = 0;
    issue({3'b011, 22'h155AA}, t);
    drop_valid();
    @(posedge clk); #1;
    @(posedge clk); #1; dir_stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; dir_stall = 1'b0;
    wait_ready(r);
    chk("xor_stall_done_cyc", last_done_cyc, t + 6);
    chk("xor_stall_ready_cyc", r, t + 7);
    chk("xor_stall_exec_cycles", exec_cnt, 5);

    exec_cnt = 0;
    issue({3'b101, 22'h00777}, t);
    drop_valid();
    wait_ready(r);
    chk("trap_illegal_cyc", last_ill_cyc, t + 2);
    chk("trap_ready_cyc", r, t + 3);
    chk("trap_no_exec", exec_cnt, 0);

    // Reset during ADD step 1 drops the instruction without done
    dc = done_cnt;
    issue({3'b010, 22'h2AAAA}, t);
    drop_valid();
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    wait_ready(r);
    chk("reset_mid_add_no_done", done_cnt, dc);
    chk("reset_mid_add_ready_cyc", r, t + 5);
    add_case("add_after_reset");

    rand_stall_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = {op, 22'($urandom())};
      issue(w, t);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        drop_valid();
        repeat (g - 1) @(posedge clk);
      end
    end
    drop_valid();
    rand_stall_en = 1'b0;
    wait_ready(r);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
